// File: rtl/bram_port_arbiter_if.sv
// Bundle of requester-side handshake signals and BRAM-side port signals
// for bram_port_arbiter.
//   req_valid/req_we/req_addr/req_data : requester requests (packed per index)
//   req_ready                          : per-requester grant
//   rsp_valid/rsp_data                 : per-requester read responses
//   ena/enb, wea/web, addra/addrb,
//   dia/dib                            : BRAM port A/B controls and write data
//   doa/dob                            : BRAM port A/B read data
// Modport slave is the arbiter view, master is the client/BRAM view.
interface bram_port_arbiter_if #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data;
    logic                          ena;
    logic                          enb;
    logic                          wea;
    logic                          web;
    logic [ADDR_WIDTH-1:0]         addra;
    logic [ADDR_WIDTH-1:0]         addrb;
    logic [DATA_WIDTH-1:0]         dia;
    logic [DATA_WIDTH-1:0]         dib;
    logic [DATA_WIDTH-1:0]         doa;
    logic [DATA_WIDTH-1:0]         dob;

    modport slave (
        input  req_valid, req_we, req_addr, req_data, doa, dob,
        output req_ready, rsp_valid, rsp_data,
        output ena, enb, wea, web, addra, addrb, dia, dib
    );

    modport master (
        output req_valid, req_we, req_addr, req_data, doa, dob,
        input  req_ready, rsp_valid, rsp_data,
        input  ena, enb, wea, web, addra, addrb, dia, dib
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares the two ports of one dual-ported BRAM among NUM_REQ requesters.
// Each cycle a round-robin scan starting at the pointer grants the first
// valid requester to port A and the next one to port B. Port B is withheld
// when both hit the same address and either one writes. Reads return their
// data to the issuing requester two cycles after the grant.
// Ports:
//   clka : clock (also clocks the BRAM)
//   rst  : asynchronous active-high reset
//   bus  : bram_port_arbiter_if.slave (requests, grants, responses, BRAM pins)
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = 3
) (
    input logic                clka,
    input logic                rst,
    bram_port_arbiter_if.slave bus
);

    // Internal arrays are padded to a power of two so an IDX_W-bit index
    // selects exactly; padding slots never request.
    localparam int SLOTS = 2**IDX_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   scan_t;

    logic [SLOTS-1:0]      valid_arr;
    logic [SLOTS-1:0]      we_arr;
    logic [ADDR_WIDTH-1:0] addr_arr [SLOTS];
    logic [DATA_WIDTH-1:0] data_arr [SLOTS];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_unpack
            if (gi < NUM_REQ) begin : g_real
                assign valid_arr[gi] = bus.req_valid[gi];
                assign we_arr[gi]    = bus.req_we[gi];
                assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
                assign data_arr[gi]  = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_pad
                assign valid_arr[gi] = 1'b0;
                assign we_arr[gi]    = 1'b0;
                assign addr_arr[gi]  = '0;
                assign data_arr[gi]  = '0;
            end
        end
    endgenerate

    function automatic idx_t next_idx(input idx_t x);
        return (x == idx_t'(NUM_REQ - 1)) ? '0 : x + idx_t'(1);
    endfunction

    idx_t  ptr_reg;
    idx_t  ptr_next;
    logic  ga_found;
    logic  gb_found;
    idx_t  ga_idx;
    idx_t  gb_idx;
    scan_t scan;
    logic  conflict;
    logic  grant_a;
    logic  grant_b;

    // Round-robin scan: first valid index from ptr goes to A, second to B.
    always_comb begin
        ga_found = 1'b0;
        gb_found = 1'b0;
        ga_idx   = '0;
        gb_idx   = '0;
        scan     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr_reg} + scan_t'(k);
            if (scan >= scan_t'(NUM_REQ)) begin
                scan = scan - scan_t'(NUM_REQ);
            end
            if (valid_arr[scan[IDX_W-1:0]]) begin
                if (!ga_found) begin
                    ga_found = 1'b1;
                    ga_idx   = scan[IDX_W-1:0];
                end else if (!gb_found) begin
                    gb_found = 1'b1;
                    gb_idx   = scan[IDX_W-1:0];
                end
            end
        end
    end

    // A write sharing an address with the other port would race inside the
    // BRAM, so B backs off; two reads of one address are harmless.
    assign conflict = (addr_arr[ga_idx] == addr_arr[gb_idx]) &&
                      (we_arr[ga_idx] || we_arr[gb_idx]);
    assign grant_a  = ga_found && !rst;
    assign grant_b  = gb_found && !conflict && !rst;

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_b) begin
            ptr_next = next_idx(gb_idx);
        end else if (grant_a) begin
            ptr_next = next_idx(ga_idx);
        end
    end

    logic [NUM_REQ-1:0] ready_vec;
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((grant_a && ga_idx == idx_t'(i)) || (grant_b && gb_idx == idx_t'(i))) begin
                ready_vec[i] = 1'b1;
            end
        end
    end
    assign bus.req_ready = ready_vec;

    assign bus.ena   = grant_a;
    assign bus.wea   = grant_a && we_arr[ga_idx];
    assign bus.addra = grant_a ? addr_arr[ga_idx] : '0;
    assign bus.dia   = grant_a ? data_arr[ga_idx] : '0;
    assign bus.enb   = grant_b;
    assign bus.web   = grant_b && we_arr[gb_idx];
    assign bus.addrb = grant_b ? addr_arr[gb_idx] : '0;
    assign bus.dib   = grant_b ? data_arr[gb_idx] : '0;

    // Stage registers remember which requester owns the read data that the
    // BRAM presents on DOA/DOB one cycle after the grant.
    logic sa_valid_reg;
    logic sb_valid_reg;
    idx_t sa_idx_reg;
    idx_t sb_idx_reg;
    logic [NUM_REQ-1:0] rsp_valid_reg;
    logic [NUM_REQ-1:0] rsp_valid_next;

    always_comb begin
        rsp_valid_next = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((sa_valid_reg && sa_idx_reg == idx_t'(i)) ||
                (sb_valid_reg && sb_idx_reg == idx_t'(i))) begin
                rsp_valid_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            ptr_reg       <= '0;
            sa_valid_reg  <= 1'b0;
            sb_valid_reg  <= 1'b0;
            sa_idx_reg    <= '0;
            sb_idx_reg    <= '0;
            rsp_valid_reg <= '0;
        end else begin
            ptr_reg       <= ptr_next;
            sa_valid_reg  <= grant_a && !we_arr[ga_idx];
            sb_valid_reg  <= grant_b && !we_arr[gb_idx];
            sa_idx_reg    <= ga_idx;
            sb_idx_reg    <= gb_idx;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;

    // Each requester holds at most one grant per cycle, so at most one port
    // can target a given slice; the slice keeps its value otherwise.
    logic [DATA_WIDTH-1:0] rsp_data_reg [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            always_ff @(posedge clka or posedge rst) begin
                if (rst) begin
                    rsp_data_reg[gi] <= '0;
                end else if (sa_valid_reg && sa_idx_reg == idx_t'(gi)) begin
                    rsp_data_reg[gi] <= bus.doa;
                end else if (sb_valid_reg && sb_idx_reg == idx_t'(gi)) begin
                    rsp_data_reg[gi] <= bus.dob;
                end
            end
            assign bus.rsp_data[gi*DATA_WIDTH +: DATA_WIDTH] = rsp_data_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: directed scenarios plus a randomized run
// checked against a request-level reference model with its own memory.
module tb_bram_port_arbiter;
    localparam int DW = 36;
    localparam int AW = 9;
    localparam int NR = 4;
    localparam int IW = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus();

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .IDX_W(IW)) dut (
        .clka (clk),
        .rst  (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port BRAM, one-cycle read latency.
    logic [DW-1:0] mem [0:511];
    always @(posedge clk) begin
        if (bus.ena) begin
            if (bus.wea) mem[bus.addra] <= bus.dia;
            bus.doa <= mem[bus.addra];
        end
        if (bus.enb) begin
            if (bus.web) mem[bus.addrb] <= bus.dib;
            bus.dob <= mem[bus.addrb];
        end
    end

    logic [NR-1:0] v_valid;
    logic [NR-1:0] v_we;
    logic [AW-1:0] v_addr [NR];
    logic [DW-1:0] v_data [NR];

    task automatic apply();
        bus.req_valid = v_valid;
        bus.req_we    = v_we;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW] = v_addr[i];
            bus.req_data[i*DW +: DW] = v_data[i];
        end
    endtask

    task automatic clear_reqs();
        v_valid = '0;
        v_we    = '0;
        for (int i = 0; i < NR; i++) begin
            v_addr[i] = '0;
            v_data[i] = '0;
        end
        apply();
    endtask

    task automatic set_req(input int i, input logic we, input int addr, input logic [DW-1:0] data);
        v_valid[i] = 1'b1;
        v_we[i]    = we;
        v_addr[i]  = AW'(addr);
        v_data[i]  = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic flush();
        clear_reqs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_reqs();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 100 + i, '0);
        apply();
        @(negedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready);
        end
        checks++;
        if ({bus.ena, bus.enb} !== 2'b00) begin
            errors++; $display("FAIL reset_en got=%b exp=00", {bus.ena, bus.enb});
        end
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== '0) begin
            errors++; $display("FAIL reset_rsp got_valid=%b exp=0000", bus.rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0011) begin
            errors++; $display("FAIL first_grant got=%b exp=0011", bus.req_ready);
        end
        checks++;
        if ({bus.ena, bus.wea, bus.addra, bus.enb, bus.web, bus.addrb} !== {2'b10, 9'd100, 2'b10, 9'd101}) begin
            errors++; $display("FAIL first_ports got A=%b%b%0d B=%b%b%0d exp A=10 100 B=10 101",
                               bus.ena, bus.wea, bus.addra, bus.enb, bus.web, bus.addrb);
        end
        $display("test_reset done");
        flush();
    endtask

    task automatic test_write_read();
        do_reset();
        set_req(2, 1'b1, 5, 36'h0ABC);
        apply();
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100 || {bus.ena, bus.wea} !== 2'b11 || bus.addra !== 9'd5 ||
            bus.dia !== 36'h0ABC || bus.enb !== 1'b0) begin
            errors++; $display("FAIL wr_grant got ready=%b ena=%b wea=%b addra=%0d dia=%h exp 0100 1 1 5 abc",
                               bus.req_ready, bus.ena, bus.wea, bus.addra, bus.dia);
        end
        @(negedge clk);
        clear_reqs();
        set_req(2, 1'b0, 5, '0);
        apply();
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100 || {bus.ena, bus.wea} !== 2'b10 || bus.addra !== 9'd5) begin
            errors++; $display("FAIL rd_grant got ready=%b ena=%b wea=%b exp 0100 1 0",
                               bus.req_ready, bus.ena, bus.wea);
        end
        @(negedge clk);
        clear_reqs();
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL rd_early got=%b exp=0000", bus.rsp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_data[2*DW +: DW] !== 36'h0ABC) begin
            errors++; $display("FAIL rd_rsp got valid=%b data=%h exp 0100 abc",
                               bus.rsp_valid, bus.rsp_data[2*DW +: DW]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.rsp_data[2*DW +: DW] !== 36'h0ABC) begin
            errors++; $display("FAIL rd_hold got valid=%b data=%h exp 0000 abc",
                               bus.rsp_valid, bus.rsp_data[2*DW +: DW]);
        end
        $display("test_write_read done");
        flush();
    endtask

    task automatic test_rotation();
        logic [NR-1:0] exp_ready;
        int ea;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 200 + i, '0);
        apply();
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_ready = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            ea        = (c % 2 == 0) ? 200 : 202;
            checks++;
            if (bus.req_ready !== exp_ready || bus.addra !== AW'(ea) || bus.addrb !== AW'(ea + 1)) begin
                errors++; $display("FAIL rotation c=%0d got ready=%b a=%0d b=%0d exp %b %0d %0d",
                                   c, bus.req_ready, bus.addra, bus.addrb, exp_ready, ea, ea + 1);
            end
            @(negedge clk);
        end
        $display("test_rotation done");
        flush();
    endtask

    task automatic test_conflict();
        do_reset();
        set_req(0, 1'b1, 7, 36'h123);
        set_req(1, 1'b0, 7, '0);
        apply();
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001 || {bus.ena, bus.wea, bus.enb} !== 3'b110 || bus.addra !== 9'd7) begin
            errors++; $display("FAIL conflict_grant got ready=%b ena=%b wea=%b enb=%b exp 0001 1 1 0",
                               bus.req_ready, bus.ena, bus.wea, bus.enb);
        end
        @(negedge clk);
        v_valid[0] = 1'b0;
        apply();
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010 || {bus.ena, bus.wea, bus.enb} !== 3'b100 || bus.addra !== 9'd7) begin
            errors++; $display("FAIL conflict_retry got ready=%b ena=%b wea=%b enb=%b exp 0010 1 0 0",
                               bus.req_ready, bus.ena, bus.wea, bus.enb);
        end
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_data[1*DW +: DW] !== 36'h123) begin
            errors++; $display("FAIL conflict_rsp got valid=%b data=%h exp 0010 123",
                               bus.rsp_valid, bus.rsp_data[1*DW +: DW]);
        end
        $display("test_conflict done");
        flush();
    endtask

    task automatic test_read_read();
        do_reset();
        set_req(0, 1'b1, 9, 36'h55);
        apply();
        @(negedge clk);
        clear_reqs();
        set_req(1, 1'b0, 9, '0);
        set_req(3, 1'b0, 9, '0);
        apply();
        #1;
        checks++;
        if (bus.req_ready !== 4'b1010 || {bus.ena, bus.enb} !== 2'b11 ||
            bus.addra !== 9'd9 || bus.addrb !== 9'd9) begin
            errors++; $display("FAIL rr_grant got ready=%b en=%b%b exp 1010 11",
                               bus.req_ready, bus.ena, bus.enb);
        end
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b1010 || bus.rsp_data[1*DW +: DW] !== 36'h55 ||
            bus.rsp_data[3*DW +: DW] !== 36'h55) begin
            errors++; $display("FAIL rr_rsp got valid=%b d1=%h d3=%h exp 1010 55 55",
                               bus.rsp_valid, bus.rsp_data[1*DW +: DW], bus.rsp_data[3*DW +: DW]);
        end
        $display("test_read_read done");
        flush();
    endtask

    task automatic test_reset_mid_read();
        int seen;
        do_reset();
        set_req(2, 1'b0, 5, '0);
        apply();
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++; $display("FAIL midrst_grant got=%b exp=0100", bus.req_ready);
        end
        @(negedge clk);
        clear_reqs();
        rst = 1'b1;
        seen = 0;
        #1;
        if (bus.rsp_valid !== 4'b0000) seen++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.rsp_valid !== 4'b0000) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL midrst_rsp got=%0d stray responses exp=0", seen);
        end
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 300 + i, '0);
        apply();
        #1;
        checks++;
        if (bus.req_ready !== 4'b0011) begin
            errors++; $display("FAIL midrst_ptr got=%b exp=0011", bus.req_ready);
        end
        $display("test_reset_mid_read done");
        flush();
    endtask

    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] ref_mem [0:511];

    task automatic test_random();
        rsp_t q[$];
        rsp_t keep[$];
        logic [DW-1:0] hold [NR];
        int order[$];
        int m_ptr;
        int ga;
        int gb;
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_valid;
        logic [1+1+AW+DW-1:0] exp_a;
        logic [1+1+AW+DW-1:0] exp_b;
        do_reset();
        for (int i = 0; i < NR; i++) hold[i] = '0;
        // Known contents for the address window used below.
        for (int a = 16; a < 24; a++) begin
            clear_reqs();
            set_req(0, 1'b1, a, {$urandom, $urandom});
            apply();
            ref_mem[a] = v_data[0];
            @(negedge clk);
        end
        m_ptr = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                v_valid[i] = ($urandom_range(0, 3) != 0);
                v_we[i]    = ($urandom_range(0, 2) == 0);
                v_addr[i]  = AW'(16 + $urandom_range(0, 7));
                v_data[i]  = {$urandom, $urandom};
            end
            apply();
            #1;
            order.delete();
            for (int k = 0; k < NR; k++) begin
                if (v_valid[(m_ptr + k) % NR]) order.push_back((m_ptr + k) % NR);
            end
            ga = (order.size() > 0) ? order[0] : -1;
            gb = (order.size() > 1) ? order[1] : -1;
            if (gb >= 0 && v_addr[ga] == v_addr[gb] && (v_we[ga] || v_we[gb])) gb = -1;
            exp_ready = '0;
            exp_a = '0;
            exp_b = '0;
            if (ga >= 0) begin
                exp_ready[ga] = 1'b1;
                exp_a = {1'b1, v_we[ga], v_addr[ga], v_data[ga]};
            end
            if (gb >= 0) begin
                exp_ready[gb] = 1'b1;
                exp_b = {1'b1, v_we[gb], v_addr[gb], v_data[gb]};
            end
            $display("rand cyc=%0d valid=%b we=%b ga=%0d gb=%0d", cyc, v_valid, v_we, ga, gb);
            checks++;
            if (bus.req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready);
            end
            checks++;
            if ({bus.ena, bus.wea, bus.addra, bus.dia} !== exp_a) begin
                errors++; $display("FAIL rand_portA cyc=%0d got=%h exp=%h", cyc,
                                   {bus.ena, bus.wea, bus.addra, bus.dia}, exp_a);
            end
            checks++;
            if ({bus.enb, bus.web, bus.addrb, bus.dib} !== exp_b) begin
                errors++; $display("FAIL rand_portB cyc=%0d got=%h exp=%h", cyc,
                                   {bus.enb, bus.web, bus.addrb, bus.dib}, exp_b);
            end
            exp_valid = '0;
            keep.delete();
            foreach (q[j]) begin
                if (q[j].due == cyc) begin
                    exp_valid[q[j].idx] = 1'b1;
                    hold[q[j].idx] = q[j].data;
                end else begin
                    keep.push_back(q[j]);
                end
            end
            q = keep;
            checks++;
            if (bus.rsp_valid !== exp_valid) begin
                errors++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_valid);
            end
            for (int i = 0; i < NR; i++) begin
                checks++;
                if (bus.rsp_data[i*DW +: DW] !== hold[i]) begin
                    errors++; $display("FAIL rand_rsp_data cyc=%0d req=%0d got=%h exp=%h",
                                       cyc, i, bus.rsp_data[i*DW +: DW], hold[i]);
                end
            end
            // Reads see memory before this cycle's writes.
            if (ga >= 0 && !v_we[ga]) q.push_back('{cyc + 2, ga, ref_mem[v_addr[ga]]});
            if (gb >= 0 && !v_we[gb]) q.push_back('{cyc + 2, gb, ref_mem[v_addr[gb]]});
            if (ga >= 0 && v_we[ga]) ref_mem[v_addr[ga]] = v_data[ga];
            if (gb >= 0 && v_we[gb]) ref_mem[v_addr[gb]] = v_data[gb];
            if (gb >= 0) m_ptr = (gb + 1) % NR;
            else if (ga >= 0) m_ptr = (ga + 1) % NR;
            @(negedge clk);
        end
        $display("test_random done");
        flush();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_rotation();
        test_conflict();
        test_read_read();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
